// File: rtl/pll_lock_sequencer_if.sv
// PLL supervision bundle: raw PLL lock status in, sequenced reset/status out.
// Latency: pure wiring, no storage.
// Backpressure: none; level-signalled status only.
interface pll_lock_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             pll_lock_stdy;
    logic             stdy_rst;
    logic             sys_rst_n;
    logic             locked;
    logic             timeout;
    logic [CNT_W-1:0] loss_count;

    // Sequencer side: consumes PLL status, drives reset and status.
    modport master (
        input  pll_lock,
        input  pll_lock_stdy,
        output stdy_rst,
        output sys_rst_n,
        output locked,
        output timeout,
        output loss_count
    );

    // PLL / observer side.
    modport slave (
        output pll_lock,
        output pll_lock_stdy,
        input  stdy_rst,
        input  sys_rst_n,
        input  locked,
        input  timeout,
        input  loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Clears the PLL sticky flag, qualifies lock, then releases a system reset.
// Latency: lock_s to sys_rst_n release = STABLE_CYCLES+1; lock loss to reset = SYNC_STAGES+1.
// Backpressure: none; all outputs are registered levels.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int STABLE_CYCLES   = 1024,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int STDY_RST_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_sequencer_if.master  bus
);

    // The phase counter serves both the CLEAR pulse and the STABLE window.
    localparam int CNT_MAX = (STABLE_CYCLES > STDY_RST_CYCLES) ? STABLE_CYCLES : STDY_RST_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    STDY_LAST   = CW'(STDY_RST_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
    localparam logic [TW-1:0]    TMR_MAX     = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]    TMR_ONE     = TW'(1);
    localparam logic [CNT_W-1:0] LOSS_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LOSS_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] stdy_sync;
    logic                   lock_s;
    logic                   stdy_s;

    state_t           state_q,     state_nxt;
    logic [CW-1:0]    cnt_q,       cnt_nxt;
    logic [TW-1:0]    tmr_q,       tmr_nxt;
    logic [TW-1:0]    tmr_inc;
    logic [CNT_W-1:0] loss_q,      loss_nxt;
    logic             timeout_q,   timeout_nxt;
    logic             stdy_rst_q,  stdy_rst_nxt;
    logic             sys_rst_n_q, sys_rst_n_nxt;
    logic             locked_q,    locked_nxt;

    // Bring both PLL status lines into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
            stdy_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_lock};
            stdy_sync <= {stdy_sync[SYNC_STAGES-2:0], bus.pll_lock_stdy};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign stdy_s = stdy_sync[SYNC_STAGES-1];

    // Timeout timer holds once it reaches its limit.
    assign tmr_inc = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_ONE;

    // Next-state, counters and next output values; outputs are decoded from
    // state_nxt so every output pin comes straight from a flop.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        tmr_nxt     = tmr_q;
        loss_nxt    = loss_q;
        timeout_nxt = timeout_q;

        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == STDY_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                    tmr_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                tmr_nxt = tmr_inc;
                if (tmr_inc == TMR_MAX) timeout_nxt = 1'b1;
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end
            end
            ST_STABLE: begin
                tmr_nxt = tmr_inc;
                if (tmr_inc == TMR_MAX) timeout_nxt = 1'b1;
                // A lock drop wins over reaching the end of the window.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s || !stdy_s) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                    loss_nxt  = (loss_q == LOSS_MAX) ? loss_q : loss_q + LOSS_ONE;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase

        stdy_rst_nxt  = (state_nxt == ST_CLEAR);
        sys_rst_n_nxt = (state_nxt == ST_RUN);
        locked_nxt    = (state_nxt == ST_RUN);
    end

    // State, counters and all output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            tmr_q       <= '0;
            loss_q      <= '0;
            timeout_q   <= 1'b0;
            stdy_rst_q  <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            tmr_q       <= tmr_nxt;
            loss_q      <= loss_nxt;
            timeout_q   <= timeout_nxt;
            stdy_rst_q  <= stdy_rst_nxt;
            sys_rst_n_q <= sys_rst_n_nxt;
            locked_q    <= locked_nxt;
        end
    end

    assign bus.stdy_rst   = stdy_rst_q;
    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.locked     = locked_q;
    assign bus.timeout    = timeout_q;
    assign bus.loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: two instances (CNT_W=8 and CNT_W=2).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Each scenario task checks its own results inline.
module tb_pll_lock_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer_if #(.CNT_W(8)) bus ();
    pll_lock_sequencer_if #(.CNT_W(2)) bus2 ();

    pll_lock_sequencer #(
        .SYNC_STAGES(2), .STABLE_CYCLES(16), .TIMEOUT_CYCLES(100),
        .STDY_RST_CYCLES(4), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    pll_lock_sequencer #(
        .SYNC_STAGES(2), .STABLE_CYCLES(16), .TIMEOUT_CYCLES(100),
        .STDY_RST_CYCLES(4), .CNT_W(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset both instances with PLL inputs low; returns on the release cycle.
    task automatic apply_reset();
        rst_n = 1'b0;
        bus.pll_lock = 1'b0;  bus.pll_lock_stdy = 1'b0;
        bus2.pll_lock = 1'b0; bus2.pll_lock_stdy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pll_lock = 1'b0;  bus.pll_lock_stdy = 1'b0;
        bus2.pll_lock = 1'b0; bus2.pll_lock_stdy = 1'b0;
        #1;
        tick();
        n_checks++; if (bus.stdy_rst !== 1'b1) begin n_fail++; $display("FAIL reset_stdy_rst: got %b expected 1", bus.stdy_rst); end
        n_checks++; if (bus.sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n: got %b expected 0", bus.sys_rst_n); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
        n_checks++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
        n_checks++; if (bus.loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_loss_count: got %0d expected 0", bus.loss_count); end
    endtask

    task automatic test_bring_up();
        int hi;
        int n;
        apply_reset();
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.stdy_rst === 1'b1) hi++;
            tick();
        end
        n_checks++; if (hi != 4) begin n_fail++; $display("FAIL bringup_stdy_rst_len: got %0d expected 4", hi); end
        bus.pll_lock = 1'b1; bus.pll_lock_stdy = 1'b1;
        n = 0;
        while (bus.sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks++; if (n != 19) begin n_fail++; $display("FAIL bringup_release_latency: got %0d expected 19", n); end
        n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL bringup_locked: got %b expected 1", bus.locked); end
        n_checks++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL bringup_timeout: got %b expected 0", bus.timeout); end
        n_checks++; if (bus.loss_count !== 8'd0) begin n_fail++; $display("FAIL bringup_loss_count: got %0d expected 0", bus.loss_count); end
    endtask

    // One-cycle lock drop arriving in STABLE when cnt = 8.
    task automatic test_stable_glitch();
        int n;
        apply_reset();
        for (int i = 0; i < 10; i++) tick();
        bus.pll_lock = 1'b1; bus.pll_lock_stdy = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        n = 0;
        while (bus.sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks++; if (n != 19) begin n_fail++; $display("FAIL glitch_relock_latency: got %0d expected 19", n); end
        n_checks++; if (bus.loss_count !== 8'd0) begin n_fail++; $display("FAIL glitch_loss_count: got %0d expected 0", bus.loss_count); end
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        n = 0;
        while (bus.stdy_rst === 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL timeout_clear_len: got %0d expected 4", n); end
        n = 0;
        while (bus.timeout !== 1'b1 && n < 300) begin tick(); n++; end
        n_checks++; if (n != 100) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 100", n); end
        bus.pll_lock = 1'b1; bus.pll_lock_stdy = 1'b1;
        n = 0;
        while (bus.sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks++; if (n != 19) begin n_fail++; $display("FAIL timeout_late_release: got %0d expected 19", n); end
        n_checks++; if (bus.timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", bus.timeout); end
    endtask

    task automatic test_lock_loss();
        int n;
        int hi;
        apply_reset();
        bus.pll_lock = 1'b1; bus.pll_lock_stdy = 1'b1;
        n = 0;
        while (bus.sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
        bus.pll_lock = 1'b0;
        n = 0;
        while (bus.sys_rst_n === 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL loss_latency: got %0d expected 3", n); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL loss_locked: got %b expected 0", bus.locked); end
        n_checks++; if (bus.loss_count !== 8'd1) begin n_fail++; $display("FAIL loss_count_1: got %0d expected 1", bus.loss_count); end
        bus.pll_lock = 1'b1;
        hi = 0;
        while (bus.stdy_rst === 1'b1 && hi < 20) begin tick(); hi++; end
        n_checks++; if (hi != 4) begin n_fail++; $display("FAIL loss_stdy_rst_len: got %0d expected 4", hi); end
        n = 0;
        while (bus.sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks++; if (n != 17) begin n_fail++; $display("FAIL loss_rerelease: got %0d expected 17", n); end
    endtask

    // Continues from RUN left by test_lock_loss.
    task automatic test_stdy_loss();
        int n;
        bus.pll_lock_stdy = 1'b0;
        n = 0;
        while (bus.sys_rst_n === 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL stdy_loss_latency: got %0d expected 3", n); end
        n_checks++; if (bus.stdy_rst !== 1'b1) begin n_fail++; $display("FAIL stdy_loss_stdy_rst: got %b expected 1", bus.stdy_rst); end
        n_checks++; if (bus.loss_count !== 8'd2) begin n_fail++; $display("FAIL loss_count_2: got %0d expected 2", bus.loss_count); end
        bus.pll_lock_stdy = 1'b1;
        n = 0;
        while (bus.locked !== 1'b1 && n < 200) begin tick(); n++; end
        n_checks++; if (n != 21) begin n_fail++; $display("FAIL stdy_loss_relock: got %0d expected 21", n); end
    endtask

    task automatic test_saturate_and_async_reset();
        int n;
        logic [1:0] exp_cnt;
        apply_reset();
        bus2.pll_lock = 1'b1; bus2.pll_lock_stdy = 1'b1;
        n = 0;
        while (bus2.sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            bus2.pll_lock = 1'b0;
            tick();
            bus2.pll_lock = 1'b1;
            n = 0;
            while (bus2.sys_rst_n === 1'b1 && n < 20) begin tick(); n++; end
            n = 0;
            while (bus2.sys_rst_n !== 1'b1 && n < 200) begin tick(); n++; end
            exp_cnt = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            n_checks++; if (bus2.loss_count !== exp_cnt) begin n_fail++; $display("FAIL sat_loss_count_%0d: got %0d expected %0d", k, bus2.loss_count, exp_cnt); end
        end
        n_checks++; if (bus2.locked !== 1'b1) begin n_fail++; $display("FAIL sat_in_run: got %b expected 1", bus2.locked); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus2.sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL async_sys_rst_n: got %b expected 0", bus2.sys_rst_n); end
        n_checks++; if (bus2.locked !== 1'b0) begin n_fail++; $display("FAIL async_locked: got %b expected 0", bus2.locked); end
        n_checks++; if (bus2.stdy_rst !== 1'b1) begin n_fail++; $display("FAIL async_stdy_rst: got %b expected 1", bus2.stdy_rst); end
        n_checks++; if (bus2.loss_count !== 2'd0) begin n_fail++; $display("FAIL async_loss_count: got %0d expected 0", bus2.loss_count); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_stable_glitch();
        test_timeout();
        test_lock_loss();
        test_stdy_loss();
        test_saturate_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
